// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-side responder for MEM-stage data requests. Each accepted request
// is serviced with a fixed LATENCY (accept in cycle T, ack in T+LATENCY).
// mem_stall freezes the pipeline from accept until the ack cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   mem_read   load request, held until ack
//   mem_write  store request, held until ack
//   addr       word address
//   wdata      store data
//   rdata      load data, valid with mem_ack on a load, held until next load
//   mem_ack    one-cycle completion pulse
//   mem_stall  pipeline freeze request (combinational)
//   req_err    one-cycle pulse after accept when read and write were both high
//   parity_err (DATA_MEM_PARITY_EN only) stored parity mismatch on a load
//
// Optional feature: define DATA_MEM_PARITY_EN to store an even-parity bit
// per word and report mismatches on loads through parity_err.
//
// FSM states:
//   state | meaning
//   IDLE  | waiting for a request; accepts on mem_read|mem_write
//   BUSY  | request captured, latency counter running
//   DONE  | ack cycle; store commits at end of cycle, load data already valid

module data_mem_responder #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ack,
    output logic              mem_stall,
    output logic              req_err
`ifdef DATA_MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_write;

    logic              req;
    logic              accept;
    logic              enter_done;
    logic              rd_op;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] mem [2**ADDR_W];
`ifdef DATA_MEM_PARITY_EN
    logic              par_mem [2**ADDR_W];
`endif

    assign req    = mem_read | mem_write;
    assign accept = (state == IDLE) && req;

    // With LATENCY=1 the load data is fetched straight from the live inputs
    // on the accept edge, before the capture registers are valid.
    assign enter_done = (next_state == DONE) && (state != DONE);
    assign rd_op      = (state == IDLE) ? (mem_read & ~mem_write) : ~cap_write;
    assign rd_addr    = (state == IDLE) ? addr : cap_addr;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The counter is loaded with LATENCY-1 and leaves BUSY
    // on the edge where it decrements to 0, giving LATENCY-1 BUSY cycles.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs. Stall drops in DONE so the pipeline advances on the ack cycle.
    always_comb begin
        mem_ack   = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = req;
            BUSY:    mem_stall = 1'b1;
            DONE:    mem_ack   = 1'b1;
            default: ;
        endcase
    end

    // Capture, latency counter, load data and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= 4'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_write <= 1'b0;
            rdata     <= '0;
            req_err   <= 1'b0;
`ifdef DATA_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            req_err <= accept & mem_read & mem_write;

            if (accept) begin
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_write <= mem_write;   // a combined request executes as a write
                cnt       <= CNT_LOAD;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_done && rd_op) begin
                rdata <= mem[rd_addr];
            end

`ifdef DATA_MEM_PARITY_EN
            parity_err <= enter_done && rd_op && (par_mem[rd_addr] != ^mem[rd_addr]);
`endif
        end
    end

    // Storage array, not reset. A store commits at the end of its ack cycle;
    // a reset before that edge leaves the array untouched.
    always_ff @(posedge clk) begin
        if (state == DONE && cap_write) begin
            mem[cap_addr] <= cap_wdata;
`ifdef DATA_MEM_PARITY_EN
            par_mem[cap_addr] <= ^cap_wdata;
`endif
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    parameter int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       mem_ack;
    logic       mem_stall;
    logic       req_err;
`ifdef DATA_MEM_PARITY_EN
    logic       parity_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain array of what the memory should hold
    logic [7:0] model_mem  [256];
    bit         model_vld  [256];
    bit         model_pbad [256];
    logic [7:0] exp_rdata;
    bit         exp_known;

    data_mem_responder #(
        .DATA_W (8),
        .ADDR_W (8),
        .LATENCY(LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .mem_ack  (mem_ack),
        .mem_stall(mem_stall),
        .req_err  (req_err)
`ifdef DATA_MEM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request starting just after a rising edge, hold it through the
    // ack cycle, then release it right after the following edge.
    task automatic run_req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
        bit         got_ack = 1'b0;
        int         ack_at  = -1;
        int         stall_n = 0;
        int         err_n   = 0;
        logic       ack_stall = 1'b1;
        logic [7:0] rd_seen = 8'h00;
        logic       pe_seen = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        for (int k = 0; k < LAT + 6 && !got_ack; k++) begin
            @(negedge clk);
            if (mem_ack) begin
                got_ack   = 1'b1;
                ack_at    = k;
                ack_stall = mem_stall;
                rd_seen   = rdata;
`ifdef DATA_MEM_PARITY_EN
                pe_seen   = parity_err;
`endif
            end else if (mem_stall) begin
                stall_n++;
            end
            if (req_err) err_n++;
            @(posedge clk);
            #1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;

        check_val("ack_latency", ack_at, LAT);
        check_val("stall_cycles", stall_n, LAT);
        check_val("stall_at_ack", {31'd0, ack_stall}, 0);
        check_val("req_err_pulses", err_n, (rd && wr) ? 1 : 0);

        if (wr) begin
            if (exp_known) check_val("rdata_hold", {24'd0, rd_seen}, {24'd0, exp_rdata});
            check_val("parity_err_wr", {31'd0, pe_seen}, 0);
            model_mem[a]  = d;
            model_vld[a]  = 1'b1;
            model_pbad[a] = 1'b0;
        end else begin
            if (model_vld[a]) begin
                check_val("rdata", {24'd0, rd_seen}, {24'd0, model_mem[a]});
                exp_rdata = model_mem[a];
                exp_known = 1'b1;
`ifdef DATA_MEM_PARITY_EN
                check_val("parity_err_rd", {31'd0, pe_seen}, {31'd0, model_pbad[a]});
`endif
            end else begin
                exp_known = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_val("idle_stall", {31'd0, mem_stall}, 0);
            check_val("idle_ack", {31'd0, mem_ack}, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'h00;
        wdata     = 8'h00;
        exp_rdata = 8'h00;
        exp_known = 1'b1;
        for (int i = 0; i < 256; i++) begin
            model_vld[i]  = 1'b0;
            model_pbad[i] = 1'b0;
            model_mem[i]  = 8'h00;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_rdata", {24'd0, rdata}, 0);
        check_val("rst_ack", {31'd0, mem_ack}, 0);
        check_val("rst_stall", {31'd0, mem_stall}, 0);
        check_val("rst_req_err", {31'd0, req_err}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic write then read
        run_req(1'b0, 1'b1, 8'h10, 8'hA5);
        idle_check(1);
        run_req(1'b1, 1'b0, 8'h10, 8'h00);
        idle_check(1);

        // Back-to-back write/read of the same address
        run_req(1'b0, 1'b1, 8'h20, 8'h3C);
        run_req(1'b1, 1'b0, 8'h20, 8'h00);
        idle_check(2);

        // Combined request executes as a write and flags req_err
        run_req(1'b1, 1'b1, 8'h05, 8'h7E);
        run_req(1'b1, 1'b0, 8'h05, 8'h00);

        // Reset in the middle of a write drops it
        run_req(1'b0, 1'b1, 8'h30, 8'h12);
        mem_write = 1'b1;
        addr      = 8'h30;
        wdata     = 8'hFF;
        @(negedge clk);
        check_val("abort_accept_stall", {31'd0, mem_stall}, 1);
        @(posedge clk);
        #2;
        reset     = 1'b1;
        mem_write = 1'b0;
        #1;
        check_val("abort_ack", {31'd0, mem_ack}, 0);
        check_val("abort_stall", {31'd0, mem_stall}, 0);
        check_val("abort_rdata", {24'd0, rdata}, 0);
        check_val("abort_req_err", {31'd0, req_err}, 0);
        @(negedge clk);
        reset     = 1'b0;
        exp_rdata = 8'h00;
        exp_known = 1'b1;
        @(posedge clk);
        #1;
        run_req(1'b1, 1'b0, 8'h30, 8'h00);

        // Top address
        run_req(1'b0, 1'b1, 8'hFF, 8'h5A);
        run_req(1'b1, 1'b0, 8'hFF, 8'h00);

`ifdef DATA_MEM_PARITY_EN
        run_req(1'b0, 1'b1, 8'h44, 8'h01);
        dut.par_mem[8'h44] = ~dut.par_mem[8'h44];
        model_pbad[8'h44]  = 1'b1;
        run_req(1'b1, 1'b0, 8'h44, 8'h00);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            int         kind;
            logic [7:0] a;
            logic [7:0] d;
            kind = $urandom_range(0, 9);
            a    = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            d    = 8'($urandom_range(0, 255));
            if (kind < 4)      run_req(1'b1, 1'b0, a, d);
            else if (kind < 8) run_req(1'b0, 1'b1, a, d);
            else               run_req(1'b1, 1'b1, a, d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        idle_check(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
